// File: rtl/riscv_i32_fetch_req_bht.sv
// Fetch request generator with a bimodal branch history table.
// Table is cleared by a one-entry-per-cycle walk after reset.
module riscv_i32_fetch_req_bht #(
  parameter int ENTRIES   = 16,
  parameter int CTR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [2:0]  fetch_action,
  input  logic [31:0] fetch_pc,
  input  logic [2:0]  mode,

  input  logic [31:0] decode_pc,
  input  logic [31:0] decode_branch_target,
  input  logic        decode_is_compressed,
  input  logic [3:0]  decode_op,
  input  logic        decode_enable_bp,

  input  logic        exec_update,
  input  logic [31:0] exec_pc,
  input  logic        exec_taken,

  output logic        ifetch_req_flush_pipeline,
  output logic [2:0]  ifetch_req_req_type,
  output logic        ifetch_req_debug_fetch,
  output logic [31:0] ifetch_req_address,
  output logic [2:0]  ifetch_req_mode,
  output logic        ifetch_req_predicted_branch,
  output logic [31:0] ifetch_req_pc_if_mispredicted,

  output logic        init_busy
);

  localparam int IDX = $clog2(ENTRIES);

  localparam logic [CTR_WIDTH-1:0] WNT =
    CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CMAX = '1;
  localparam logic [IDX-1:0] LAST = IDX'(ENTRIES - 1);

  localparam logic [2:0] ACT_NONE    = 3'd0;
  localparam logic [2:0] ACT_HOLD    = 3'd1;
  localparam logic [2:0] ACT_FETCH   = 3'd2;
  localparam logic [2:0] ACT_RESTART = 3'd3;
  localparam logic [2:0] ACT_NEXT    = 3'd4;

  localparam logic [2:0] MODE_DEBUG  = 3'd7;

  localparam logic [3:0] OP_BRANCH   = 4'd0;
  localparam logic [3:0] OP_JAL      = 4'd1;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t               state;
  logic [IDX-1:0]       ptr;
  logic [CTR_WIDTH-1:0] bht [ENTRIES];

  logic [IDX-1:0]       lookup_idx;
  logic [IDX-1:0]       update_idx;
  logic [CTR_WIDTH-1:0] lookup_ctr;
  logic [CTR_WIDTH-1:0] update_cur;
  logic [CTR_WIDTH-1:0] update_nxt;

  logic                 predict;
  logic [31:0]          pc_plus_inst;
  logic [31:0]          next_pc;
  logic                 sequential;
  logic [31:0]          mispred_pc;

  logic                 unused_exec;

  assign lookup_idx  = decode_pc[IDX:1];
  assign update_idx  = exec_pc[IDX:1];
  assign unused_exec = ^{exec_pc[31:IDX+1], exec_pc[0]};

  // Init walk: reset parks at INIT, one entry per cycle, then RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      ptr       <= '0;
      init_busy <= 1'b1;
    end else begin
      unique case (state)
        INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state     <= RUN;
            init_busy <= 1'b0;
          end
        end
        RUN: begin
          state     <= RUN;
          init_busy <= 1'b0;
        end
        default: begin
          state     <= INIT;
          ptr       <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Saturating step for the entry addressed by the resolving branch.
  always_comb begin
    update_cur = bht[update_idx];
    update_nxt = update_cur;
    if (exec_taken) begin
      if (update_cur != CMAX) begin
        update_nxt = update_cur + 1'b1;
      end
    end else begin
      if (update_cur != '0) begin
        update_nxt = update_cur - 1'b1;
      end
    end
  end

  // Table writes: init fill while walking, branch training once running.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        bht[ptr] <= WNT;
      end else if (exec_update) begin
        bht[update_idx] <= update_nxt;
      end
    end
  end

  // Prediction from the pre-update table contents.
  always_comb begin
    lookup_ctr = bht[lookup_idx];
    predict    = 1'b0;
    if (decode_enable_bp && !init_busy) begin
      if (decode_op == OP_JAL) begin
        predict = 1'b1;
      end else if (decode_op == OP_BRANCH) begin
        predict = lookup_ctr[CTR_WIDTH-1];
      end
    end
  end

  assign pc_plus_inst =
    decode_pc + (decode_is_compressed ? 32'd2 : 32'd4);

  // Pick the followed path and the recovery path.
  always_comb begin
    if (predict) begin
      next_pc    = decode_branch_target;
      sequential = 1'b0;
      mispred_pc = pc_plus_inst;
    end else begin
      next_pc    = pc_plus_inst;
      sequential = 1'b1;
      mispred_pc = decode_branch_target;
    end
  end

  // Request decode, with debug-region fetches overriding the type.
  always_comb begin
    ifetch_req_flush_pipeline     = 1'b1;
    ifetch_req_req_type           = 3'd0;
    ifetch_req_address            = fetch_pc;
    ifetch_req_debug_fetch        = 1'b0;
    ifetch_req_mode               = MODE_DEBUG;
    ifetch_req_predicted_branch   = predict;
    ifetch_req_pc_if_mispredicted = mispred_pc;

    unique case (fetch_action)
      ACT_HOLD: begin
        ifetch_req_flush_pipeline = 1'b0;
        ifetch_req_req_type       = 3'd0;
      end
      ACT_FETCH: begin
        ifetch_req_flush_pipeline = 1'b1;
        ifetch_req_req_type       = 3'd1;
      end
      ACT_RESTART: begin
        ifetch_req_flush_pipeline = 1'b0;
        ifetch_req_req_type       = 3'd3;
      end
      ACT_NEXT: begin
        ifetch_req_flush_pipeline = 1'b0;
        ifetch_req_address        = next_pc;
        if (!sequential) begin
          ifetch_req_req_type = 3'd1;
        end else if (decode_is_compressed) begin
          ifetch_req_req_type = 3'd6;
        end else begin
          ifetch_req_req_type = 3'd2;
        end
      end
      default: begin
        ifetch_req_flush_pipeline = 1'b1;
        ifetch_req_req_type       = 3'd0;
      end
    endcase

    if (mode == MODE_DEBUG
        && fetch_action != ACT_NONE
        && fetch_action != ACT_HOLD
        && ifetch_req_address[31:8] == 24'hffffff) begin
      ifetch_req_req_type    = 3'd0;
      ifetch_req_debug_fetch = 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_i32_fetch_req_bht.sv
// Randomised bench for the BHT fetch request block.
// Reference keeps plain integer counters and a countdown for init.
module tb_riscv_i32_fetch_req_bht;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  fetch_action;
  logic [31:0] fetch_pc;
  logic [2:0]  mode;
  logic [31:0] decode_pc;
  logic [31:0] decode_branch_target;
  logic        decode_is_compressed;
  logic [3:0]  decode_op;
  logic        decode_enable_bp;
  logic        exec_update;
  logic [31:0] exec_pc;
  logic        exec_taken;

  logic        ifetch_req_flush_pipeline;
  logic [2:0]  ifetch_req_req_type;
  logic        ifetch_req_debug_fetch;
  logic [31:0] ifetch_req_address;
  logic [2:0]  ifetch_req_mode;
  logic        ifetch_req_predicted_branch;
  logic [31:0] ifetch_req_pc_if_mispredicted;
  logic        init_busy;

  int errors = 0;
  int checks = 0;

  int m_ctr [16];
  int m_init_left = 16;

  always #5 clk = ~clk;

  riscv_i32_fetch_req_bht #(
    .ENTRIES   (16),
    .CTR_WIDTH (2)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .fetch_action                  (fetch_action),
    .fetch_pc                      (fetch_pc),
    .mode                          (mode),
    .decode_pc                     (decode_pc),
    .decode_branch_target          (decode_branch_target),
    .decode_is_compressed          (decode_is_compressed),
    .decode_op                     (decode_op),
    .decode_enable_bp              (decode_enable_bp),
    .exec_update                   (exec_update),
    .exec_pc                       (exec_pc),
    .exec_taken                    (exec_taken),
    .ifetch_req_flush_pipeline     (ifetch_req_flush_pipeline),
    .ifetch_req_req_type           (ifetch_req_req_type),
    .ifetch_req_debug_fetch        (ifetch_req_debug_fetch),
    .ifetch_req_address            (ifetch_req_address),
    .ifetch_req_mode               (ifetch_req_mode),
    .ifetch_req_predicted_branch   (ifetch_req_predicted_branch),
    .ifetch_req_pc_if_mispredicted (ifetch_req_pc_if_mispredicted),
    .init_busy                     (init_busy)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 1) % 32'd16);
  endfunction

  // Reference state advance for one clock edge.
  task automatic model_edge();
    if (reset) begin
      m_init_left = 16;
    end else if (m_init_left > 0) begin
      m_init_left--;
      if (m_init_left == 0) begin
        for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      end
    end else if (exec_update) begin
      int k;
      k = idx_of(exec_pc);
      if (exec_taken) m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
      else            m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Expected outputs from the current inputs and reference state.
  task automatic check_all(string tag);
    logic        pred;
    logic [31:0] plus;
    logic [31:0] nxt;
    logic [31:0] mis;
    logic        flush;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic        dbg;
    pred = 1'b0;
    if (decode_enable_bp && m_init_left == 0) begin
      if (decode_op == 4'd1) pred = 1'b1;
      else if (decode_op == 4'd0)
        pred = (m_ctr[idx_of(decode_pc)] >= 2);
    end
    plus = decode_pc + (decode_is_compressed ? 32'd2 : 32'd4);
    nxt  = pred ? decode_branch_target : plus;
    mis  = pred ? plus : decode_branch_target;
    addr = fetch_pc;
    case (fetch_action)
      3'd1:    begin flush = 0; typ = 0; end
      3'd2:    begin flush = 1; typ = 1; end
      3'd3:    begin flush = 0; typ = 3; end
      3'd4: begin
        flush = 0;
        addr  = nxt;
        typ   = pred ? 3'd1 : (decode_is_compressed ? 3'd6 : 3'd2);
      end
      default: begin flush = 1; typ = 0; end
    endcase
    dbg = 1'b0;
    if (mode == 3'd7 && fetch_action > 3'd1
        && addr >= 32'hffffff00) begin
      dbg = 1'b1;
      typ = 3'd0;
    end
    chk({tag, "_busy"},  32'(init_busy), 32'(m_init_left > 0));
    chk({tag, "_pred"},  32'(ifetch_req_predicted_branch), 32'(pred));
    chk({tag, "_addr"},  ifetch_req_address, addr);
    chk({tag, "_type"},  32'(ifetch_req_req_type), 32'(typ));
    chk({tag, "_flush"}, 32'(ifetch_req_flush_pipeline), 32'(flush));
    chk({tag, "_dbg"},   32'(ifetch_req_debug_fetch), 32'(dbg));
    chk({tag, "_mode"},  32'(ifetch_req_mode), 32'd7);
    chk({tag, "_mis"},   ifetch_req_pc_if_mispredicted, mis);
  endtask

  task automatic lookup_branch(logic [31:0] pc, logic [31:0] tgt);
    fetch_action         = 3'd4;
    decode_pc            = pc;
    decode_branch_target = tgt;
    decode_is_compressed = 1'b0;
    decode_op            = 4'd0;
    decode_enable_bp     = 1'b1;
  endtask

  task automatic count_busy(string tag);
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk(tag, n, 16);
  endtask

  initial begin
    reset                = 1'b1;
    fetch_action         = 3'd0;
    fetch_pc             = 32'h0;
    mode                 = 3'd0;
    decode_pc            = 32'h0;
    decode_branch_target = 32'h0;
    decode_is_compressed = 1'b0;
    decode_op            = 4'd0;
    decode_enable_bp     = 1'b0;
    exec_update          = 1'b0;
    exec_pc              = 32'h0;
    exec_taken           = 1'b0;

    step();
    chk("rst_busy", 32'(init_busy), 32'd1);
    reset = 1'b0;

    // Training attempts during init must be ignored.
    lookup_branch(32'h100, 32'h2000);
    decode_op   = 4'd1;
    exec_update = 1'b1;
    exec_pc     = 32'h100;
    exec_taken  = 1'b1;
    #1;
    chk("init_jal_pred", 32'(ifetch_req_predicted_branch), 32'd0);
    check_all("init");
    count_busy("init_len");
    exec_update = 1'b0;
    decode_op   = 4'd0;
    #1;
    chk("run_busy", 32'(init_busy), 32'd0);

    check_all("wnt");
    chk("wnt_addr", ifetch_req_address, 32'h104);
    chk("wnt_type", 32'(ifetch_req_req_type), 32'd2);
    chk("wnt_pred", 32'(ifetch_req_predicted_branch), 32'd0);
    chk("wnt_mis", ifetch_req_pc_if_mispredicted, 32'h2000);

    exec_update = 1'b1;
    exec_pc     = 32'h100;
    exec_taken  = 1'b1;
    step();
    step();
    exec_update = 1'b0;
    #1;
    check_all("st");
    chk("st_pred", 32'(ifetch_req_predicted_branch), 32'd1);
    chk("st_addr", ifetch_req_address, 32'h2000);
    chk("st_type", 32'(ifetch_req_req_type), 32'd1);
    chk("st_mis", ifetch_req_pc_if_mispredicted, 32'h104);

    exec_update = 1'b1;
    exec_taken  = 1'b0;
    for (int i = 0; i < 4; i++) step();
    exec_update = 1'b0;
    #1;
    check_all("sn");
    chk("sn_model", m_ctr[idx_of(32'h100)], 0);

    exec_update = 1'b1;
    exec_taken  = 1'b1;
    step();
    #1;
    check_all("byp0");
    chk("byp0_pred", 32'(ifetch_req_predicted_branch), 32'd0);
    step();
    exec_update = 1'b0;
    #1;
    check_all("byp1");
    chk("byp1_pred", 32'(ifetch_req_predicted_branch), 32'd1);

    mode         = 3'd7;
    fetch_action = 3'd2;
    fetch_pc     = 32'hffffff40;
    #1;
    check_all("dbg2");
    chk("dbg2_type", 32'(ifetch_req_req_type), 32'd0);
    chk("dbg2_dbg", 32'(ifetch_req_debug_fetch), 32'd1);
    chk("dbg2_flush", 32'(ifetch_req_flush_pipeline), 32'd1);
    fetch_action = 3'd1;
    #1;
    check_all("dbg1");
    chk("dbg1_dbg", 32'(ifetch_req_debug_fetch), 32'd0);

    // Reset landing in the middle of the init walk.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    count_busy("reinit_len");
    check_all("reinit");

    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      fetch_action = 3'($urandom_range(0, 7));
      fetch_pc     = ($urandom_range(0, 1) == 1)
                     ? {24'hffffff, 8'($urandom)} : $urandom;
      mode         = ($urandom_range(0, 1) == 1)
                     ? 3'd7 : 3'($urandom);
      decode_pc    = ($urandom_range(0, 9) == 0)
                     ? (32'hfffffffc | 32'($urandom_range(0, 2)))
                     : (32'h1000 | ($urandom & 32'h3e));
      decode_branch_target = ($urandom_range(0, 3) == 0)
                     ? {24'hffffff, 8'($urandom)} : $urandom;
      decode_is_compressed = 1'($urandom);
      decode_op    = ($urandom_range(0, 3) == 0)
                     ? 4'($urandom) : 4'($urandom_range(0, 1));
      decode_enable_bp = ($urandom_range(0, 7) != 0);
      exec_update  = 1'($urandom);
      exec_pc      = 32'h1000 | ($urandom & 32'h3e);
      exec_taken   = 1'($urandom);
      #1;
      check_all("rnd");
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
